buttons_pio_in: RTL
===================

Name: buttons_pio_in

Overview:
- Avalon-MM slave parallel input port: the read-side counterpart of the LED output PIO.
- Samples WIDTH asynchronous board inputs (push-buttons/switches) through a 2-flop synchroniser and a per-bit debounce counter.
- Captures selected edges into sticky bits and raises a level interrupt.
- Sits on the system interconnect beside the LED PIO; same bus shape: 2-bit word address, 32-bit data, zero-wait-state reads.

Parameters:
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 16: consecutive stable clk cycles needed to accept a new level. 0 = bypass; debounced value follows the synchroniser output every cycle.
- EDGE_TYPE, 1: capture edge. 0 = rising, 1 = falling, 2 = any.
- RESET_VALUE, {WIDTH{1'b1}}: reset value of the synchroniser and debounce state. Matches the idle level of active-low buttons, so no spurious edge occurs after reset.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- address, in, 2: word address.
- chipselect, in, 1: slave select.
- write_n, in, 1: active-low write strobe.
- writedata, in, 32: write data.
- readdata, out, 32: read data, combinational from address and registers.
- in_port, in, WIDTH: asynchronous external inputs.
- irq, out, 1: level interrupt, active-high.

Behaviour:
- Reset: sync1, sync2 and deb = RESET_VALUE; all debounce counters = 0; irq_mask = 0; edge_capture = 0; irq = 0.
- Register map, read values zero-extended to 32 bits:
  - addr 0: read deb (debounced data); writes ignored.
  - addr 1: reads 0; writes ignored.
  - addr 2: irq_mask, R/W. A write loads writedata[WIDTH-1:0] when chipselect && !write_n.
  - addr 3: edge_capture, R/W1C. A write clears every bit i where writedata[i] = 1.
- Reads: no read strobe; readdata is valid in the same cycle as address and has no side effects.
- Synchroniser: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit i, with DEBOUNCE_CYCLES = N > 0:
  - if sync2[i] == deb[i]: cnt[i] <= 0.
  - else if cnt[i] == N-1: deb[i] <= sync2[i]; cnt[i] <= 0.
  - else: cnt[i] <= cnt[i] + 1.
  - Counter width is clog2(N), minimum 1. A glitch shorter than N cycles at sync2 never reaches deb.
- Latency: a clean in_port change reaches deb N+2 clk edges after first being sampled (2 edges when N = 0).
- Edge detect: deb_prev <= deb every cycle (reset RESET_VALUE).
  - rise = deb & ~deb_prev; fall = ~deb & deb_prev.
  - edge = rise, fall or (rise|fall), per EDGE_TYPE.
  - edge_capture bit sets on the clk edge after deb changes, i.e. N+3 edges after the input is sampled.
- edge_capture update: edge_capture <= (edge_capture & ~clear_mask) | edge.
  - An edge and a W1C of the same bit in the same cycle leave the bit set (set wins).
  - Edges are captured regardless of irq_mask.
- irq = |(edge_capture & irq_mask[WIDTH-1:0]), combinational from registers only.
  - Unmasking an already-captured bit asserts irq on the next cycle after the write.
- Reset asserted mid-debounce or with irq pending: immediate return to reset values. irq drops asynchronously.
- Writes with chipselect = 0 are ignored. Address bits above the map do not exist (2-bit address).

Test Plan:
1. Reset: hold in_port = 4'hF and release reset_n. Read addr 0 -> 0x0000000F. Read addr 3 -> 0. irq = 0 for 50 cycles.
2. Debounce (N = 16):
   - Drive in_port[0] low for 10 cycles, then high. addr 0 stays 0xF; addr 3 stays 0.
   - Drive in_port[0] low steadily. addr 0 reads 0xE exactly 18 clk edges after the sampling edge.
3. Edge capture (EDGE_TYPE = 1):
   - Press bit 2 (in_port = 4'hB). addr 3 reads 0x4 one cycle after deb changes; irq = 0 (mask 0).
   - Release bit 2: no new bit set.
4. IRQ and W1C:
   - With edge_capture = 0x4, write addr 2 = 0x4 -> irq = 1 next cycle.
   - Write addr 3 = 0x1 -> still 0x4, irq = 1.
   - Write addr 3 = 0x4 -> 0x0, irq = 0.
5. Collision: time a W1C of bit 1 to the same cycle as a new bit-1 falling edge -> edge_capture[1] = 1 afterwards.
6. Mid-operation reset: pulse reset_n low with irq = 1 and a debounce count in progress. irq falls without a clock; all registers read reset values; no edge is captured after release while in_port = 4'hF.

Source files
------------

// File: rtl/buttons_pio_in.sv
`default_nettype none
// =============================================================================
// buttons_pio_in: Avalon-MM input PIO (sync, debounce, edge capture, irq)
// Revision 1.0
// =============================================================================
module buttons_pio_in #(
  parameter int              WIDTH           = 4,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter int              EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q;
  logic [WIDTH-1:0] edge_capture_d;
  logic [WIDTH-1:0] clear_mask;
  logic             wr_en;
  logic             unused_writedata;

  // Synchroniser resets to the idle level so release of reset creates no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign deb = sync2_q;
    end else begin : g_debounce
      localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q [WIDTH];
      logic [CNT_W-1:0] cnt_d [WIDTH];
      logic [WIDTH-1:0] deb_q;
      logic [WIDTH-1:0] deb_d;

      // A bit is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
      always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_d[i] = '0;
          if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          deb_q <= RESET_VALUE;
          for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
          end
        end else begin
          deb_q <= deb_d;
          for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
          end
        end
      end

      assign deb = deb_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_prev_q <= RESET_VALUE;
    end else begin
      deb_prev_q <= deb;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = deb & ~deb_prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~deb & deb_prev_q;
    end else begin : g_any
      assign edge_det = deb ^ deb_prev_q;
    end
  endgenerate

  // New edges are ORed in after the clear, so a same-cycle edge beats a W1C.
  always_comb begin
    wr_en          = chipselect && !write_n;
    irq_mask_d     = irq_mask_q;
    clear_mask     = '0;
    if (wr_en && (address == ADDR_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE)) begin
      clear_mask = writedata[WIDTH-1:0];
    end
    edge_capture_d = (edge_capture_q & ~clear_mask) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = deb;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture_q;
      default:   readdata = '0;
    endcase
  end

  assign irq              = |(edge_capture_q & irq_mask_q);
  assign unused_writedata = ^writedata;

endmodule
`default_nettype wire
